// File: rtl/ecc_scrub_pkg.sv
// Shared definitions for the ECC scrub controller: state encoding, default
// widths and the saturating-increment helper.
package ecc_scrub_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CAPTURE   = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_VERIFY    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_CAPTURE   = ST_CAPTURE,
        S_WRITEBACK = ST_WRITEBACK,
        S_VERIFY    = ST_VERIFY
    } scrub_state_t;

    localparam int DEF_DATA_W     = 26;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_MAX_RETRY  = 3;
    localparam int DEF_VERIFY_LAT = 1;

    // Holds at max_val instead of wrapping; widths up to 64 bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter used for the scrub error and fix statistics.
module ecc_sat_counter
    import ecc_scrub_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] out
);

    localparam logic [63:0] MAX_VAL = 64'({CNT_W{1'b1}});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (inc) begin
            out <= CNT_W'(sat_inc(64'(out), MAX_VAL));
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Scrub controller around a mem_with_ecc_N: writes corrected words back,
// verifies and retries. Optional ECC_SCRUB_THRESH_EN adds a sticky error-threshold alarm.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | watching reads for a flagged error; host owns write port
// CAPTURE   | corrected word latched; host write here aborts the scrub
// WRITEBACK | controller drives the write port with the captured word
// VERIFY    | waiting VERIFY_LAT cycles, then sampling mem_error
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int VERIFY_LAT = DEF_VERIFY_LAT
`ifdef ECC_SCRUB_THRESH_EN
    ,
    parameter int ERR_THRESH = 8
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_error,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_stall,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              scrub_busy,
    output logic              scrub_done,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  fix_count,
    output logic              fail
`ifdef ECC_SCRUB_THRESH_EN
    ,
    output logic              thresh_alarm
`endif
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int WAIT_W  = $clog2(VERIFY_LAT + 1);

    scrub_state_t        state;
    logic [DATA_W-1:0]   capture_q;
    logic [RETRY_W-1:0]  retry_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                err_inc;
    logic                fix_inc;
    logic                verify_tc;

    assign err_inc   = (state == S_IDLE) && rd_valid && mem_error;
    // Last VERIFY cycle: mem_error now reflects the freshly written word.
    assign verify_tc = (state == S_VERIFY) && (wait_q == WAIT_W'(1));
    assign fix_inc   = verify_tc && !host_we && !mem_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            capture_q  <= '0;
            retry_q    <= '0;
            wait_q     <= '0;
            scrub_done <= 1'b0;
            fail       <= 1'b0;
        end else begin
            scrub_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A simultaneous host write supersedes the faulty word.
                    if (rd_valid && mem_error && !host_we) begin
                        capture_q <= mem_data_out;
                        retry_q   <= '0;
                        state     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    state <= host_we ? S_IDLE : S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    retry_q <= retry_q + RETRY_W'(1);
                    wait_q  <= WAIT_W'(VERIFY_LAT);
                    state   <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (host_we) begin
                        state <= S_IDLE;
                    end else if (verify_tc) begin
                        if (!mem_error) begin
                            scrub_done <= 1'b1;
                            state      <= S_IDLE;
                        end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
                            fail  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_WRITEBACK;
                        end
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we      = host_we;
        mem_data_in = host_data;
        host_stall  = 1'b0;
        if (state == S_WRITEBACK) begin
            mem_we      = 1'b1;
            mem_data_in = capture_q;
            host_stall  = host_we;
        end
    end

    assign scrub_busy = (state != S_IDLE);

    ecc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (err_inc),
        .out   (err_count)
    );

    ecc_sat_counter #(.CNT_W(CNT_W)) u_fix_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fix_inc),
        .out   (fix_count)
    );

`ifdef ECC_SCRUB_THRESH_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thresh_alarm <= 1'b0;
        end else if (err_inc &&
                     (sat_inc(64'(err_count), 64'({CNT_W{1'b1}})) >= 64'(ERR_THRESH))) begin
            thresh_alarm <= 1'b1;
        end
    end
`endif

endmodule
